// File: rtl/alarm_timer.sv
// Purpose : countdown timer for the alarm FSM; loads a seconds value and pulses expired at zero.
// Latency : start -> busy/remaining next cycle; expired N*CLK_FREQ edges after start (next cycle if N=0).
// Backpressure: none; start_timer is accepted in every state and always restarts the count.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start_timer, value  : one-cycle load request and seconds to count
//   pause               : freezes the countdown (only with `define TIMER_PAUSE_EN)
//   expired             : one-cycle pulse when the count reaches zero
//   busy                : high while counting
//   remaining           : seconds left (registered, holds after expiry)
//   one_hz_enable       : divider tick, one cycle per CLK_FREQ cycles while counting
//
// Optional feature macro: TIMER_PAUSE_EN (adds the pause input).

module alarm_timer #(
  parameter int CLK_FREQ = 27000000,
  parameter int TIME_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_timer,
  input  logic [TIME_W-1:0] value,
`ifdef TIMER_PAUSE_EN
  input  logic              pause,
`endif
  output logic              expired,
  output logic              busy,
  output logic [TIME_W-1:0] remaining,
  output logic              one_hz_enable
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [DIV_W-1:0]  divider;
  logic [DIV_W-1:0]  divider_n;
  logic [TIME_W-1:0] remaining_n;
  logic              hold;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // The tick is a decode of registered state; pause suppresses it in the same
  // cycle so a frozen divider sitting at its last value never fires.
  assign one_hz_enable = (state == COUNT) && (divider == DIV_LAST) && !hold;

  always_comb begin
    state_n     = state;
    divider_n   = divider;
    remaining_n = remaining;
    if (start_timer) begin
      // A start always wins, including over pause and over an EXPIRE cycle.
      remaining_n = value;
      divider_n   = '0;
      state_n     = (value != '0) ? COUNT : EXPIRE;
    end else begin
      case (state)
        COUNT: begin
          if (!hold) begin
            if (divider == DIV_LAST) begin
              divider_n = '0;
              // Treat <=1 as the last second so the count can never wrap.
              if (remaining <= TIME_W'(1)) begin
                remaining_n = '0;
                state_n     = EXPIRE;
              end else begin
                remaining_n = remaining - TIME_W'(1);
              end
            end else begin
              divider_n = divider + DIV_W'(1);
            end
          end
        end
        EXPIRE: begin
          divider_n = '0;
          state_n   = IDLE;
        end
        default: begin
          divider_n = '0;
          state_n   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      divider   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_n;
      divider   <= divider_n;
      remaining <= remaining_n;
      busy      <= (state_n == COUNT);
      expired   <= (state_n == EXPIRE);
    end
  end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 CLK_FREQ, 27000000, clock cycles per timer second (>=2).
REQ-002 TIME_W, 4, width of loaded/remaining seconds value.
REQ-003 clock  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start_timer  input  1  one-cycle request from alarm FSM to load value and begin countdown.
REQ-006 value  input  TIME_W  seconds to count, sampled only on the edge where start_timer=1.
REQ-007 pause  input  1  freeze countdown (present only when TIMER_PAUSE_EN defined).
REQ-008 expired  output  1  one-cycle pulse consumed by alarm FSM as timer_status.
REQ-009 busy  output  1  high while in COUNT.
REQ-010 remaining  output  TIME_W  seconds left, registered.
REQ-011 one_hz_enable  output  1  divider tick, high one cycle per CLK_FREQ cycles during COUNT.

Function
REQ-012 Divider SHALL count 0..CLK_FREQ-1 in COUNT; one_hz_enable=1 exactly when divider==CLK_FREQ-1, divider then wraps to 0.
REQ-013 Divider SHALL be held at 0 in IDLE and EXPIRE and cleared to 0 on every accepted start_timer, so the first second is full length.
REQ-014 States SHALL be IDLE, COUNT, EXPIRE; expired=1 iff state==EXPIRE; busy=1 iff state==COUNT.
REQ-015 start_timer=1 in any state SHALL load remaining<=value, clear divider, next state COUNT if value!=0 else EXPIRE.
REQ-016 In COUNT with one_hz_enable=1 and no start: remaining==1 -> remaining<=0, next EXPIRE; else remaining<=remaining-1.
REQ-017 EXPIRE SHALL last exactly one cycle then go to IDLE unless start_timer=1 that cycle (REQ-015 applies; expired still high that cycle).
REQ-018 For start accepted at edge t with value N>=1, expired SHALL first be high in the cycle after edge t+N*CLK_FREQ; N=0 -> high in cycle after edge t.
REQ-019 start_timer during COUNT SHALL restart with new value; no expired pulse for the abandoned count.
REQ-020 remaining SHALL hold its value in IDLE and EXPIRE (0 after natural expiry).
REQ-021 Decrement SHALL never wrap below 0.

Reset
REQ-022 reset=1 SHALL force state IDLE, divider 0, remaining 0, expired 0, busy 0, one_hz_enable 0 on the next edge.
REQ-023 reset SHALL take priority over start_timer and pause in the same cycle.
REQ-024 reset mid-COUNT SHALL abort with no expired pulse.

Configuration
REQ-025 Macro TIMER_PAUSE_EN defined: pause port exists; pause=1 in COUNT freezes divider and remaining, one_hz_enable=0; start_timer overrides pause.
REQ-026 TIMER_PAUSE_EN undefined: no pause port; countdown never freezes.

Verification (CLK_FREQ=4, TIME_W=4)
REQ-027 reset, then start_timer with value=3 -> busy high, remaining 3,2,1 at 4-cycle steps, expired one-cycle pulse 12 cycles after start edge, then IDLE, remaining=0.
REQ-028 start_timer with value=0 -> expired high in the very next cycle, busy never high.
REQ-029 value=5 started, after 6 cycles start_timer with value=2 -> remaining 2, expired 8 cycles after second start, exactly one pulse total.
REQ-030 value=4 started, reset asserted after 7 cycles -> all outputs 0, no expired pulse within 30 further cycles.
REQ-031 start_timer asserted in EXPIRE cycle with value=1 -> expired high that cycle, busy next cycle, second expired 4 cycles later.
REQ-032 TIMER_PAUSE_EN: value=2, pause high cycles 2-11 -> remaining frozen, expired 18 cycles after start.
